// File: rtl/rab_inv_sequencer_if.sv
// Request, table-read and clear signals between the range-invalidation sequencer and its environment.
// Latency: none, wires only.
// Backpressure: InvReady_SO gates requests and Stall_SI freezes the walk. The slave modport is the sequencer side.
interface rab_inv_sequencer_if #(
  parameter int AW        = 32,
  parameter int PAGE_BITS = 12,
  parameter int N_SLICES  = 16,
  parameter int L2_N      = 1024
);
  localparam int SW = $clog2(N_SLICES);
  localparam int LW = $clog2(L2_N);

  // invalidation request / status
  logic                    InvReq_SI;
  logic [AW-1:0]           InvBegin_DI;
  logic [AW-1:0]           InvEnd_DI;
  logic                    InvReady_SO;
  logic                    InvDone_SO;
  logic [15:0]             InvCount_DO;
  logic                    Stall_SI;

  // L1 slice table
  logic [SW-1:0]           SliceIdx_DO;
  logic [AW-1:0]           SliceBegin_DI;
  logic [AW-1:0]           SliceEnd_DI;
  logic                    SliceEn_DI;
  logic                    SliceClr_SO;

  // L2 TLB
  logic                    L2RdEn_SO;
  logic [LW-1:0]           L2RdAddr_DO;
  logic [AW-PAGE_BITS-1:0] L2Page_DI;
  logic                    L2Valid_DI;
  logic                    L2Clr_SO;
  logic [LW-1:0]           L2ClrAddr_DO;

  modport slave (
    input  InvReq_SI, InvBegin_DI, InvEnd_DI, Stall_SI,
    input  SliceBegin_DI, SliceEnd_DI, SliceEn_DI,
    input  L2Page_DI, L2Valid_DI,
    output InvReady_SO, InvDone_SO, InvCount_DO,
    output SliceIdx_DO, SliceClr_SO,
    output L2RdEn_SO, L2RdAddr_DO, L2Clr_SO, L2ClrAddr_DO
  );

  modport master (
    output InvReq_SI, InvBegin_DI, InvEnd_DI, Stall_SI,
    output SliceBegin_DI, SliceEnd_DI, SliceEn_DI,
    output L2Page_DI, L2Valid_DI,
    input  InvReady_SO, InvDone_SO, InvCount_DO,
    input  SliceIdx_DO, SliceClr_SO,
    input  L2RdEn_SO, L2RdAddr_DO, L2Clr_SO, L2ClrAddr_DO
  );
endinterface

// File: rtl/rab_inv_sequencer.sv
// Walks all L1 slices and then all L2 TLB entries. It clears every enabled or valid entry that overlaps a latched VA range.
// Latency: accept to InvDone_SO takes N_SLICES + L2_N + 2 cycles, plus one cycle for every stalled cycle.
// Backpressure: InvReady_SO is low while walking. Stall_SI freezes indices and the pending L2 compare, and it suppresses all strobes.
module rab_inv_sequencer #(
  parameter int AW           = 32,
  parameter int PAGE_BITS    = 12,
  parameter int N_SLICES     = 16,
  parameter int L2_N_SETS    = 32,
  parameter int L2_N_ENTRIES = 32
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  rab_inv_sequencer_if.slave    bus
);
  localparam int L2_N = L2_N_SETS * L2_N_ENTRIES;
  localparam int SW   = $clog2(N_SLICES);
  localparam int LW   = $clog2(L2_N);
  localparam int PW   = AW - PAGE_BITS;

  localparam logic [SW-1:0] SLICE_LAST = SW'(N_SLICES - 1);
  localparam logic [LW-1:0] L2_LAST    = LW'(L2_N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1_WALK,
    S_L2_WALK,
    S_L2_DRAIN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] begin_q, begin_d;
  logic [AW-1:0] end_q, end_d;
  logic [SW-1:0] slice_idx_q, slice_idx_d;
  logic [LW-1:0] rd_idx_q, rd_idx_d;
  logic          cmp_vld_q, cmp_vld_d;   // an L2 read is outstanding and awaits its compare
  logic [LW-1:0] cmp_idx_q, cmp_idx_d;
  logic [15:0]   count_q, count_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;

  logic          go;
  logic [PW-1:0] begin_page;
  logic [PW-1:0] end_page;
  logic          slice_hit;
  logic          page_hit;
  logic          slice_clr;
  logic          l2_rd;
  logic          l2_clr;

  // Overlap tests against the latched range. The strobes are combinational because the table data
  // arrives in the same cycle as the index (L1) or one cycle after the read (L2).
  always_comb begin
    go         = !bus.Stall_SI && !Rst_RI;
    begin_page = begin_q[AW-1:PAGE_BITS];
    end_page   = end_q[AW-1:PAGE_BITS];
    slice_hit  = bus.SliceEn_DI && (bus.SliceBegin_DI <= end_q) && (bus.SliceEnd_DI >= begin_q);
    page_hit   = bus.L2Valid_DI && (begin_page <= bus.L2Page_DI) && (bus.L2Page_DI <= end_page);
    slice_clr  = (state_q == S_L1_WALK) && go && slice_hit;
    l2_rd      = (state_q == S_L2_WALK) && go;
    l2_clr     = cmp_vld_q && go && page_hit;
  end

  // Next-state logic: walk sequencing, the compare pipeline and the saturating clear counter.
  always_comb begin
    state_d     = state_q;
    begin_d     = begin_q;
    end_d       = end_q;
    slice_idx_d = slice_idx_q;
    rd_idx_d    = rd_idx_q;
    cmp_vld_d   = cmp_vld_q;
    cmp_idx_d   = cmp_idx_q;
    count_d     = count_q;
    ready_d     = ready_q;
    done_d      = 1'b0;

    if ((slice_clr || l2_clr) && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.InvReq_SI && ready_q) begin
          begin_d     = bus.InvBegin_DI;
          end_d       = bus.InvEnd_DI;
          count_d     = '0;
          slice_idx_d = '0;
          rd_idx_d    = '0;
          cmp_vld_d   = 1'b0;
          ready_d     = 1'b0;
          state_d     = S_L1_WALK;
        end
      end
      S_L1_WALK: begin
        if (!bus.Stall_SI) begin
          if (slice_idx_q == SLICE_LAST) begin
            rd_idx_d = '0;
            state_d  = S_L2_WALK;
          end else begin
            slice_idx_d = slice_idx_q + SW'(1);
          end
        end
      end
      S_L2_WALK: begin
        if (!bus.Stall_SI) begin
          cmp_vld_d = 1'b1;
          cmp_idx_d = rd_idx_q;
          if (rd_idx_q == L2_LAST) begin
            state_d = S_L2_DRAIN;
          end else begin
            rd_idx_d = rd_idx_q + LW'(1);
          end
        end
      end
      S_L2_DRAIN: begin
        if (!bus.Stall_SI) begin
          cmp_vld_d = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        cmp_vld_d = 1'b0;
        ready_d   = 1'b1;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State register. A reset mid-walk simply returns to idle. Clears already issued are not undone.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q     <= S_IDLE;
      begin_q     <= '0;
      end_q       <= '0;
      slice_idx_q <= '0;
      rd_idx_q    <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_idx_q   <= '0;
      count_q     <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      begin_q     <= begin_d;
      end_q       <= end_d;
      slice_idx_q <= slice_idx_d;
      rd_idx_q    <= rd_idx_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_idx_q   <= cmp_idx_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
    end
  end

  assign bus.InvReady_SO  = ready_q;
  assign bus.InvDone_SO   = done_q;
  assign bus.InvCount_DO  = count_q;
  assign bus.SliceIdx_DO  = slice_idx_q;
  assign bus.SliceClr_SO  = slice_clr;
  assign bus.L2RdEn_SO    = l2_rd;
  assign bus.L2RdAddr_DO  = rd_idx_q;
  assign bus.L2Clr_SO     = l2_clr;
  assign bus.L2ClrAddr_DO = cmp_idx_q;
endmodule

// File: tb/tb_rab_inv_sequencer.sv
// Directed bench for rab_inv_sequencer. It provides behavioural L1 slice and L2 TLB storage.
// Latency: the L2 storage returns read data one cycle after L2RdEn_SO and holds it while no read is issued.
// Backpressure: Stall_SI and Rst_RI are injected from the walk driver at chosen walk positions.
module tb_rab_inv_sequencer;
  localparam int N_SLICES = 16;
  localparam int L2_N     = 1024;
  localparam int WALK     = N_SLICES + L2_N + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rab_inv_sequencer_if #(.AW(32), .PAGE_BITS(12), .N_SLICES(N_SLICES), .L2_N(L2_N)) bus ();

  rab_inv_sequencer #(
    .AW(32), .PAGE_BITS(12), .N_SLICES(N_SLICES), .L2_N_SETS(32), .L2_N_ENTRIES(32)
  ) dut (
    .Clk_CI (clk),
    .Rst_RI (rst),
    .bus    (bus)
  );

  // table storage
  logic [31:0] sl_begin [N_SLICES];
  logic [31:0] sl_end   [N_SLICES];
  logic        sl_en    [N_SLICES];
  logic [19:0] l2_page  [L2_N];
  logic        l2_valid [L2_N];
  logic [19:0] rd_page  = '0;
  logic        rd_valid = 1'b0;

  assign bus.SliceBegin_DI = sl_begin[bus.SliceIdx_DO];
  assign bus.SliceEnd_DI   = sl_end[bus.SliceIdx_DO];
  assign bus.SliceEn_DI    = sl_en[bus.SliceIdx_DO];
  assign bus.L2Page_DI     = rd_page;
  assign bus.L2Valid_DI    = rd_valid;

  always @(posedge clk) begin
    if (bus.L2RdEn_SO) begin
      rd_page  <= l2_page[bus.L2RdAddr_DO];
      rd_valid <= l2_valid[bus.L2RdAddr_DO];
    end
  end

  int checks = 0;
  int failures = 0;

  // observations from the last walk
  logic [15:0] slice_mask;
  int          l2q[$];
  int          stall_viol;
  int          done_cyc;
  int          done_pulses;
  logic        ready_after;
  logic [15:0] count_at_done;
  int          busy_ready;
  int          post_rst_clr;
  logic        ready_post_rst;
  logic [15:0] count_post_rst;

  task automatic setup_tables(input bit l1_pages, input int l1_n, input bit l2_pages);
    for (int i = 0; i < N_SLICES; i++) begin
      if (l1_pages && i < l1_n) begin
        sl_begin[i] = 32'(i) * 32'h1000;
        sl_end[i]   = 32'(i) * 32'h1000 + 32'h0FFF;
        sl_en[i]    = 1'b1;
      end else begin
        // disabled slices deliberately overlap everything
        sl_begin[i] = 32'h0000_0000;
        sl_end[i]   = 32'hFFFF_FFFF;
        sl_en[i]    = 1'b0;
      end
    end
    for (int i = 0; i < L2_N; i++) begin
      l2_page[i]  = 20'(i);
      l2_valid[i] = l2_pages;
    end
  endtask

  // Drives one request and follows the walk at negedges until done+3 or the cycle limit.
  // Cycle c counts the negedges after the accepting clock edge.
  task automatic run_walk(input logic [31:0] b, input logic [31:0] e, input int stall_at,
                          input int rst_at, input bit poke, input int limit);
    int   st_left = 0;
    bit   trig = 0;
    bit   rst_done = 0;
    int   rst_cyc = -1;
    logic n_stall, n_rst, n_req;
    slice_mask = '0; l2q.delete(); stall_viol = 0; done_cyc = -1; done_pulses = 0;
    ready_after = 1'b0; count_at_done = 16'hDEAD; busy_ready = 0; post_rst_clr = 0;
    ready_post_rst = 1'b0; count_post_rst = 16'hDEAD;
    @(posedge clk); #1;
    bus.InvReq_SI = 1'b1; bus.InvBegin_DI = b; bus.InvEnd_DI = e;
    @(posedge clk); #1;
    // the range must have been latched, so garbage on the inputs from now on must not matter
    bus.InvReq_SI = 1'b0; bus.InvBegin_DI = 32'h0; bus.InvEnd_DI = 32'hFFFF_FFFF;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (bus.SliceClr_SO) begin
        slice_mask[bus.SliceIdx_DO] = 1'b1;
        if (rst_done) post_rst_clr++;
      end
      if (bus.L2Clr_SO) begin
        l2q.push_back(int'(bus.L2ClrAddr_DO));
        if (rst_done) post_rst_clr++;
      end
      if (bus.Stall_SI && (bus.SliceClr_SO || bus.L2RdEn_SO || bus.L2Clr_SO)) stall_viol++;
      if (bus.InvDone_SO) begin
        done_pulses++;
        if (done_cyc < 0) begin
          done_cyc = c;
          count_at_done = bus.InvCount_DO;
        end
      end
      if (done_cyc >= 0 && c == done_cyc + 1) ready_after = bus.InvReady_SO;
      if (poke && c >= 3 && c < 10 && bus.InvReady_SO) busy_ready++;
      if (rst_cyc >= 0 && c == rst_cyc + 1) begin
        ready_post_rst = bus.InvReady_SO;
        count_post_rst = bus.InvCount_DO;
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      n_stall = bus.Stall_SI; n_rst = 1'b0; n_req = 1'b0;
      if (bus.Stall_SI) begin
        st_left--;
        if (st_left == 0) n_stall = 1'b0;
      end else if (stall_at >= 0 && !trig && bus.L2RdEn_SO && int'(bus.L2RdAddr_DO) == stall_at) begin
        n_stall = 1'b1; st_left = 3; trig = 1;
      end
      if (rst_at > 0 && !rst_done && !bus.InvReady_SO && int'(bus.SliceIdx_DO) == rst_at - 1) begin
        n_rst = 1'b1; rst_done = 1; rst_cyc = c + 1;
      end
      if (poke && c >= 2 && c < 9) n_req = 1'b1;
      @(posedge clk); #1;
      bus.Stall_SI = n_stall; rst = n_rst; bus.InvReq_SI = n_req;
    end
    bus.Stall_SI = 1'b0; rst = 1'b0; bus.InvReq_SI = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.InvReady_SO !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.InvReady_SO); end
    checks++; if (bus.InvDone_SO !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.InvDone_SO); end
    checks++; if (bus.InvCount_DO !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0000", bus.InvCount_DO); end
    checks++; if ({bus.SliceClr_SO, bus.L2RdEn_SO, bus.L2Clr_SO} !== 3'b000) begin
      failures++; $display("FAIL reset_strobes got=%b exp=000", {bus.SliceClr_SO, bus.L2RdEn_SO, bus.L2Clr_SO}); end
    checks++; if (bus.SliceIdx_DO !== 4'd0 || bus.L2RdAddr_DO !== 10'd0) begin
      failures++; $display("FAIL reset_idx got=%0d/%0d exp=0/0", bus.SliceIdx_DO, bus.L2RdAddr_DO); end
  endtask

  task automatic test_l1_range();
    setup_tables(1'b1, 4, 1'b0);
    run_walk(32'h1000, 32'h1FFF, -1, 0, 1'b0, 1200);
    checks++; if (slice_mask !== 16'h0002) begin failures++; $display("FAIL l1_mask got=%h exp=0002", slice_mask); end
    checks++; if (l2q.size() != 0) begin failures++; $display("FAIL l1_l2clr got=%0d exp=0", l2q.size()); end
    checks++; if (count_at_done !== 16'd1) begin failures++; $display("FAIL l1_count got=%0d exp=1", count_at_done); end
    checks++; if (done_cyc != WALK) begin failures++; $display("FAIL l1_latency got=%0d exp=%0d", done_cyc, WALK); end
    checks++; if (done_pulses != 1) begin failures++; $display("FAIL l1_done_pulses got=%0d exp=1", done_pulses); end
  endtask

  task automatic test_l2_range();
    setup_tables(1'b0, 0, 1'b1);
    l2_page[500] = 20'd6; l2_valid[500] = 1'b0;   // matching page but invalid
    run_walk(32'h5000, 32'h7FFF, -1, 0, 1'b0, 1200);
    checks++; if (l2q.size() != 3 || l2q[0] != 5 || l2q[1] != 6 || l2q[2] != 7) begin
      failures++; $display("FAIL l2_clears got=n%0d {%0d,%0d,%0d} exp=n3 {5,6,7}", l2q.size(), l2q[0], l2q[1], l2q[2]); end
    checks++; if (slice_mask !== 16'h0) begin failures++; $display("FAIL l2_slices got=%h exp=0000", slice_mask); end
    checks++; if (count_at_done !== 16'd3) begin failures++; $display("FAIL l2_count got=%0d exp=3", count_at_done); end
    checks++; if (ready_after !== 1'b1) begin failures++; $display("FAIL l2_ready_after got=%b exp=1", ready_after); end
  endtask

  task automatic test_single_addr();
    setup_tables(1'b1, 4, 1'b1);
    run_walk(32'h1FFF, 32'h1FFF, -1, 0, 1'b0, 1200);
    checks++; if (slice_mask !== 16'h0002) begin failures++; $display("FAIL single_mask got=%h exp=0002", slice_mask); end
    checks++; if (l2q.size() != 1 || l2q[0] != 1) begin
      failures++; $display("FAIL single_l2 got=n%0d first=%0d exp=n1 first=1", l2q.size(), l2q[0]); end
    checks++; if (count_at_done !== 16'd2) begin failures++; $display("FAIL single_count got=%0d exp=2", count_at_done); end
  endtask

  task automatic test_reversed();
    setup_tables(1'b1, 4, 1'b1);
    run_walk(32'h8000, 32'h1000, -1, 0, 1'b0, 1200);
    checks++; if (slice_mask !== 16'h0 || l2q.size() != 0) begin
      failures++; $display("FAIL rev_clears got=%h/%0d exp=0000/0", slice_mask, l2q.size()); end
    checks++; if (done_pulses != 1) begin failures++; $display("FAIL rev_done got=%0d exp=1", done_pulses); end
    checks++; if (ready_after !== 1'b1) begin failures++; $display("FAIL rev_ready got=%b exp=1", ready_after); end
    checks++; if (count_at_done !== 16'd0) begin failures++; $display("FAIL rev_count got=%0d exp=0", count_at_done); end
  endtask

  task automatic test_stall();
    setup_tables(1'b0, 0, 1'b1);
    run_walk(32'h9000, 32'hBFFF, 10, 0, 1'b0, 1200);
    checks++; if (l2q.size() != 3 || l2q[0] != 9 || l2q[1] != 10 || l2q[2] != 11) begin
      failures++; $display("FAIL stall_clears got=n%0d {%0d,%0d,%0d} exp=n3 {9,10,11}", l2q.size(), l2q[0], l2q[1], l2q[2]); end
    checks++; if (stall_viol != 0) begin failures++; $display("FAIL stall_strobes got=%0d exp=0", stall_viol); end
    checks++; if (done_cyc != WALK + 3) begin failures++; $display("FAIL stall_latency got=%0d exp=%0d", done_cyc, WALK + 3); end
    checks++; if (count_at_done !== 16'd3) begin failures++; $display("FAIL stall_count got=%0d exp=3", count_at_done); end
  endtask

  task automatic test_back_to_back_req();
    setup_tables(1'b0, 0, 1'b1);
    run_walk(32'h5000, 32'h7FFF, -1, 0, 1'b1, 1200);
    checks++; if (l2q.size() != 3 || l2q[0] != 5 || l2q[2] != 7) begin
      failures++; $display("FAIL busy_clears got=n%0d exp=n3 {5,6,7}", l2q.size()); end
    checks++; if (busy_ready != 0) begin failures++; $display("FAIL busy_ready got=%0d exp=0", busy_ready); end
    checks++; if (done_cyc != WALK || done_pulses != 1) begin
      failures++; $display("FAIL busy_done got=%0d/%0d exp=%0d/1", done_cyc, done_pulses, WALK); end
  endtask

  task automatic test_reset_mid();
    setup_tables(1'b1, 16, 1'b1);
    run_walk(32'h0, 32'hFFFF_FFFF, -1, 5, 1'b0, 1100);
    checks++; if (slice_mask !== 16'h001F) begin failures++; $display("FAIL rstmid_mask got=%h exp=001f", slice_mask); end
    checks++; if (post_rst_clr != 0 || l2q.size() != 0) begin
      failures++; $display("FAIL rstmid_clears got=%0d/%0d exp=0/0", post_rst_clr, l2q.size()); end
    checks++; if (done_pulses != 0) begin failures++; $display("FAIL rstmid_done got=%0d exp=0", done_pulses); end
    checks++; if (ready_post_rst !== 1'b1 || count_post_rst !== 16'd0) begin
      failures++; $display("FAIL rstmid_idle got=%b/%0d exp=1/0", ready_post_rst, count_post_rst); end
  endtask

  initial begin
    bus.InvReq_SI = 1'b0; bus.InvBegin_DI = '0; bus.InvEnd_DI = '0; bus.Stall_SI = 1'b0;
    setup_tables(1'b0, 0, 1'b0);
    test_reset();
    test_l1_range();
    test_l2_range();
    test_single_addr();
    test_reversed();
    test_stall();
    test_back_to_back_req();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
